// File: rtl/input_unit.sv
// Input unit of the 3D mesh router: flit FIFO, head-flit route lock and switch request.
// Optional macro IU_LFSR_EN selects the Galois LFSR tie-break; otherwise a toggle bit is used.

package input_unit_pkg;
    typedef struct packed {
        logic [2:0] z;
        logic [2:0] y;
        logic [2:0] x;
    } position_t;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        EAST  = 3'd1,
        WEST  = 3'd2,
        NORTH = 3'd3,
        SOUTH = 3'd4,
        UP    = 3'd5,
        DOWN  = 3'd6
    } port_t;
endpackage

module input_unit
    import input_unit_pkg::*;
#(
    parameter int             BUF_DEPTH  = 4,
    parameter int             FLIT_WIDTH = 32,
    parameter logic [7:0]     LFSR_SEED  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FLIT_WIDTH-1:0] in_flit,

    output position_t             rc_dest,
    output logic                  rc_rand_bit,
    input  port_t                 rc_outport,

    output logic                  sa_req,
    output port_t                 sa_port,
    input  logic                  sa_grant,

    output logic                  out_valid,
    output logic [FLIT_WIDTH-1:0] out_flit,

    output logic                  err_orphan
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int POS_W = $bits(position_t);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [FLIT_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;

    state_t                state_q, state_d;
    port_t                 route_q, route_d;
    logic                  out_valid_q, out_valid_d;
    logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
    logic                  err_orphan_q, err_orphan_d;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  capture;
    logic [FLIT_WIDTH-1:0] front;
    logic                  front_head;
    logic                  front_tail;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign front      = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign front_head = front[FLIT_WIDTH-1];
    assign front_tail = front[FLIT_WIDTH-2];

    assign in_ready   = !full;
    assign push       = in_valid && !full;

    assign rc_dest    = position_t'(front[POS_W-1:0]);
    assign sa_req     = (state_q == ACTIVE) && !empty;
    assign sa_port    = route_q;
    assign out_valid  = out_valid_q;
    assign out_flit   = out_flit_q;
    assign err_orphan = err_orphan_q;

    always_comb begin
        state_d      = state_q;
        route_d      = route_q;
        out_valid_d  = 1'b0;
        out_flit_d   = out_flit_q;
        err_orphan_d = 1'b0;
        pop          = 1'b0;
        capture      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (front_head) begin
                        // Head stays in the FIFO; it is forwarded once granted.
                        route_d = rc_outport;
                        capture = 1'b1;
                        state_d = ACTIVE;
                    end else begin
                        pop          = 1'b1;
                        err_orphan_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (sa_req && sa_grant) begin
                    pop         = 1'b1;
                    out_valid_d = 1'b1;
                    out_flit_d  = front;
                    if (front_tail) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    end

    // Storage carries no reset; only pointers define occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= in_flit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= IDLE;
            route_q      <= LOCAL;
            out_valid_q  <= 1'b0;
            out_flit_q   <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            state_q      <= state_d;
            route_q      <= route_d;
            out_valid_q  <= out_valid_d;
            out_flit_q   <= out_flit_d;
            err_orphan_q <= err_orphan_d;
        end
    end

`ifdef IU_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
    endfunction

    always_comb begin
        lfsr_d = lfsr_q;
        if (capture) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rc_rand_bit = lfsr_q[0];
`else
    logic rand_bit_q, rand_bit_d;
    logic unused_seed;

    assign unused_seed = ^LFSR_SEED;

    always_comb begin
        rand_bit_d = rand_bit_q;
        if (capture) begin
            rand_bit_d = !rand_bit_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rand_bit_q <= 1'b0;
        end else begin
            rand_bit_q <= rand_bit_d;
        end
    end

    assign rc_rand_bit = rand_bit_q;
`endif

endmodule

// File: tb/tb_input_unit.sv
// Directed self-checking bench for input_unit (route lock, FIFO full, orphan discard, tie-break, reset).
module tb_input_unit;
    import input_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_flit;
    position_t   rc_dest;
    logic        rc_rand_bit;
    port_t       rc_outport;
    logic        sa_req;
    port_t       sa_port;
    logic        sa_grant;
    logic        out_valid;
    logic [31:0] out_flit;
    logic        err_orphan;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef IU_LFSR_EN
    localparam logic RB0 = 1'b1, RB1 = 1'b0, RB2 = 1'b1;
`else
    localparam logic RB0 = 1'b0, RB1 = 1'b1, RB2 = 1'b0;
`endif

    input_unit #(.BUF_DEPTH(4), .FLIT_WIDTH(32), .LFSR_SEED(8'hA5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_flit    (in_flit),
        .rc_dest    (rc_dest),
        .rc_rand_bit(rc_rand_bit),
        .rc_outport (rc_outport),
        .sa_req     (sa_req),
        .sa_port    (sa_port),
        .sa_grant   (sa_grant),
        .out_valid  (out_valid),
        .out_flit   (out_flit),
        .err_orphan (err_orphan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mkflit(input logic h, input logic t,
                                           input logic [11:0] pay, input logic [8:0] dst);
        return {h, t, 9'd0, pay, dst};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] f;
        logic [31:0] pk [4];
        logic [31:0] fx;
        logic [31:0] ob, hs, fa, fb;
        int          n_err, n_out;
        logic [31:0] last_out;

        in_valid   = 1'b0;
        in_flit    = '0;
        rc_outport = LOCAL;
        sa_grant   = 1'b0;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_in_ready",  in_ready,    1'b1);
        chk("rst_sa_req",    sa_req,      1'b0);
        chk("rst_out_valid", out_valid,   1'b0);
        chk("rst_out_flit",  out_flit,    32'h0);
        chk("rst_err",       err_orphan,  1'b0);
        chk("rst_sa_port",   sa_port,     LOCAL);
        chk("rst_rand",      rc_rand_bit, RB0);
        next_cycle();

        // Single-flit packet to EAST
        f = mkflit(1'b1, 1'b1, 12'h111, 9'o123);
        in_valid = 1'b1; in_flit = f; rc_outport = EAST; sa_grant = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_dest",     rc_dest, f[8:0]);
        chk("t1_req_idle", sa_req,  1'b0);
        next_cycle();
        @(negedge clk);
        chk("t1_req",  sa_req,  1'b1);
        chk("t1_port", sa_port, EAST);
        next_cycle();
        @(negedge clk);
        chk("t1_ovalid", out_valid, 1'b1);
        chk("t1_oflit",  out_flit,  f);
        chk("t1_req_done", sa_req,  1'b0);
        next_cycle();
        @(negedge clk);
        chk("t1_ovalid_low", out_valid, 1'b0);
        next_cycle();

        // Four-flit packet locked to UP while route result changes to WEST
        for (int i = 0; i < 4; i++) pk[i] = mkflit(i == 0, i == 3, 12'h200 + 12'(i), 9'o321);
        for (int k = 0; k < 8; k++) begin
            in_valid   = (k < 4);
            in_flit    = (k < 4) ? pk[k] : 32'h0;
            rc_outport = (k < 2) ? UP : WEST;
            sa_grant   = 1'b1;
            @(negedge clk);
            if (k >= 2 && k <= 5) begin
                chk($sformatf("t2_req_%0d", k),  sa_req,  1'b1);
                chk($sformatf("t2_port_%0d", k), sa_port, UP);
            end else begin
                chk($sformatf("t2_noreq_%0d", k), sa_req, 1'b0);
            end
            if (k >= 3 && k <= 6) begin
                chk($sformatf("t2_ovalid_%0d", k), out_valid, 1'b1);
                chk($sformatf("t2_oflit_%0d", k),  out_flit,  pk[k-3]);
            end else begin
                chk($sformatf("t2_novalid_%0d", k), out_valid, 1'b0);
            end
            next_cycle();
        end

        // Fill the FIFO with grant low, then one grant cycle while offering a flit
        for (int i = 0; i < 4; i++) pk[i] = mkflit(i == 0, i == 3, 12'h300 + 12'(i), 9'o045);
        fx = mkflit(1'b0, 1'b0, 12'hBAD, 9'o777);
        rc_outport = NORTH;
        sa_grant   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_flit  = pk[k];
            @(negedge clk);
            chk($sformatf("t3_ready_%0d", k), in_ready, 1'b1);
            next_cycle();
        end
        in_valid = 1'b1; in_flit = fx; sa_grant = 1'b1;
        @(negedge clk);
        chk("t3_full",   in_ready, 1'b0);
        chk("t3_req",    sa_req,   1'b1);
        chk("t3_port",   sa_port,  NORTH);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_ready_after", in_ready,  1'b1);
        chk("t3_ovalid_5",    out_valid, 1'b1);
        chk("t3_oflit_5",     out_flit,  pk[0]);
        next_cycle();
        for (int k = 6; k < 9; k++) begin
            @(negedge clk);
            chk($sformatf("t3_ovalid_%0d", k), out_valid, 1'b1);
            chk($sformatf("t3_oflit_%0d", k),  out_flit,  pk[k-5]);
            next_cycle();
        end
        @(negedge clk);
        chk("t3_drained_valid", out_valid,  1'b0);
        chk("t3_drained_req",   sa_req,     1'b0);
        chk("t3_no_orphan",     err_orphan, 1'b0);
        next_cycle();

        // Orphan body flit in IDLE, followed by a normal head to SOUTH
        ob = mkflit(1'b0, 1'b0, 12'h0B0, 9'o111);
        hs = mkflit(1'b1, 1'b1, 12'h4A5, 9'o222);
        rc_outport = SOUTH;
        sa_grant   = 1'b1;
        n_err = 0; n_out = 0; last_out = '0;
        for (int k = 0; k < 8; k++) begin
            in_valid = (k < 2);
            in_flit  = (k == 0) ? ob : hs;
            @(negedge clk);
            if (err_orphan) n_err++;
            if (out_valid) begin
                n_out++;
                last_out = out_flit;
            end
            if (k == 2) chk("t4_err_cycle", err_orphan, 1'b1);
            if (k == 3) chk("t4_port", sa_port, SOUTH);
            next_cycle();
        end
        chk("t4_err_count", n_err,    1);
        chk("t4_out_count", n_out,    1);
        chk("t4_out_flit",  last_out, hs);

        // Tie-break bit across two back-to-back single-flit packets from reset
        do_reset();
        fa = mkflit(1'b1, 1'b1, 12'hA00, 9'o000);
        fb = mkflit(1'b1, 1'b1, 12'hB00, 9'o010);
        rc_outport = WEST;
        sa_grant   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = (k < 2);
            in_flit  = (k == 0) ? fa : fb;
            @(negedge clk);
            if (k == 0) chk("t5_rand0", rc_rand_bit, RB0);
            if (k == 2) chk("t5_rand1", rc_rand_bit, RB1);
            if (k == 3) chk("t5_out_a", out_flit,    fa);
            if (k == 4) chk("t5_rand2", rc_rand_bit, RB2);
            if (k == 5) chk("t5_out_b", out_flit,    fb);
            next_cycle();
        end

        // Asynchronous reset in the middle of a packet
        for (int i = 0; i < 3; i++) pk[i] = mkflit(i == 0, 1'b0, 12'h600 + 12'(i), 9'o567);
        rc_outport = EAST;
        sa_grant   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_flit  = pk[k];
            next_cycle();
        end
        in_valid = 1'b0;
        sa_grant = 1'b1;
        next_cycle();
        sa_grant = 1'b0;
        @(negedge clk);
        chk("t6_pre_ovalid", out_valid, 1'b1);
        chk("t6_pre_req",    sa_req,    1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready",  in_ready,    1'b1);
        chk("t6_rst_req",    sa_req,      1'b0);
        chk("t6_rst_port",   sa_port,     LOCAL);
        chk("t6_rst_ovalid", out_valid,   1'b0);
        chk("t6_rst_oflit",  out_flit,    32'h0);
        chk("t6_rst_err",    err_orphan,  1'b0);
        chk("t6_rst_rand",   rc_rand_bit, RB0);
        next_cycle();
        rst_n = 1'b1;
        f = mkflit(1'b1, 1'b1, 12'h7D7, 9'o654);
        rc_outport = DOWN;
        sa_grant   = 1'b1;
        in_valid   = 1'b1;
        in_flit    = f;
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_fresh_dest", rc_dest, f[8:0]);
        chk("t6_fresh_idle", sa_req,  1'b0);
        next_cycle();
        @(negedge clk);
        chk("t6_fresh_req",  sa_req,  1'b1);
        chk("t6_fresh_port", sa_port, DOWN);
        next_cycle();
        @(negedge clk);
        chk("t6_fresh_ovalid", out_valid,  1'b1);
        chk("t6_fresh_oflit",  out_flit,   f);
        chk("t6_fresh_err",    err_orphan, 1'b0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
